// File: rtl/alarma_multicanal_if.sv
// ============================================================================
// Module   : alarma_multicanal_if
// Brief    : Control, sensor and indicator bundle for the multichannel alarm.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alarma_multicanal_if #(
    parameter int N  = 3,
    parameter int CW = 4
);
    logic          armar;
    logic          desarmar;
    logic [N-1:0]  sensores;
    logic [N-1:0]  mascara;
    logic [1:0]    estado;
    logic          armado;
    logic          aviso;
    logic          sirena;
    logic [N-1:0]  disparo;
    logic [CW-1:0] cuenta;

    // The master drives the buttons and sensors and watches the indicators.
    modport master (
        output armar, desarmar, sensores, mascara,
        input  estado, armado, aviso, sirena, disparo, cuenta
    );

    modport slave (
        input  armar, desarmar, sensores, mascara,
        output estado, armado, aviso, sirena, disparo, cuenta
    );
endinterface

`default_nettype wire

// File: rtl/alarma_multicanal.sv
// ============================================================================
// Module   : alarma_multicanal
// Brief    : N-channel armed alarm with entry delay and sticky trip record.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alarma_multicanal #(
    parameter int           N            = 3,
    parameter int           DELAY        = 8,
    parameter logic [N-1:0] RETARDO_MASK = N'(1)
) (
    input  wire logic          clk,
    input  wire logic          reset,
    alarma_multicanal_if.slave bus
);
    localparam int          CW      = $clog2(DELAY + 1);
    localparam logic [CW-1:0] c_delay = CW'(DELAY);
    localparam logic [CW-1:0] c_uno   = CW'(1);

    typedef enum logic [1:0] {
        S_DESARMADO = 2'b00,
        S_ARMADO    = 2'b01,
        S_RETARDO   = 2'b10,
        S_ALARMA    = 2'b11
    } state_t;

    state_t        r_estado;
    logic [CW-1:0] r_cuenta;
    logic [N-1:0]  r_disparo;
    logic          r_armado;
    logic          r_aviso;
    logic          r_sirena;

    state_t        w_next;
    logic [CW-1:0] w_cuenta_nx;
    logic [N-1:0]  w_disparo_nx;
    logic [N-1:0]  w_activo;
    logic [N-1:0]  w_inst;
    logic [N-1:0]  w_ret;

    assign w_activo = bus.sensores & bus.mascara;
    assign w_inst   = w_activo & ~RETARDO_MASK;
    assign w_ret    = w_activo & RETARDO_MASK;

    always_comb begin
        w_next       = r_estado;
        w_cuenta_nx  = r_cuenta;
        w_disparo_nx = r_disparo;
        case (r_estado)
            S_DESARMADO: begin
                // Disarm wins over arm, so both together leave the record intact.
                if (bus.armar && !bus.desarmar) begin
                    w_next       = S_ARMADO;
                    w_disparo_nx = '0;
                end
            end
            S_ARMADO: begin
                if (bus.desarmar) begin
                    w_next = S_DESARMADO;
                end else begin
                    w_disparo_nx = r_disparo | w_activo;
                    if (|w_inst) begin
                        w_next = S_ALARMA;
                    end else if (|w_ret) begin
                        w_next      = S_RETARDO;
                        w_cuenta_nx = c_delay;
                    end
                end
            end
            S_RETARDO: begin
                if (bus.desarmar) begin
                    w_next      = S_DESARMADO;
                    w_cuenta_nx = '0;
                end else begin
                    w_disparo_nx = r_disparo | w_activo;
                    // Further delayed trips never reload the running count.
                    if ((|w_inst) || (r_cuenta == c_uno)) begin
                        w_next      = S_ALARMA;
                        w_cuenta_nx = '0;
                    end else begin
                        w_cuenta_nx = r_cuenta - c_uno;
                    end
                end
            end
            S_ALARMA: begin
                if (bus.desarmar) begin
                    w_next = S_DESARMADO;
                end else begin
                    w_disparo_nx = r_disparo | w_activo;
                end
            end
            default: begin
                w_next      = S_DESARMADO;
                w_cuenta_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado  <= S_DESARMADO;
            r_cuenta  <= '0;
            r_disparo <= '0;
            r_armado  <= 1'b0;
            r_aviso   <= 1'b0;
            r_sirena  <= 1'b0;
        end else begin
            r_estado  <= w_next;
            r_cuenta  <= w_cuenta_nx;
            r_disparo <= w_disparo_nx;
            r_armado  <= (w_next != S_DESARMADO);
            r_aviso   <= (w_next == S_RETARDO);
            r_sirena  <= (w_next == S_ALARMA);
        end
    end

    assign bus.estado  = r_estado;
    assign bus.cuenta  = r_cuenta;
    assign bus.disparo = r_disparo;
    assign bus.armado  = r_armado;
    assign bus.aviso   = r_aviso;
    assign bus.sirena  = r_sirena;

endmodule

`default_nettype wire

// File: tb/tb_alarma_multicanal.sv
// ============================================================================
// Module   : tb_alarma_multicanal
// Brief    : Directed bench for two alarm configurations (3ch/4 and 8ch/1).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alarma_multicanal;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    alarma_multicanal_if #(.N(3), .CW(3)) bus_a ();
    alarma_multicanal_if #(.N(8), .CW(1)) bus_b ();

    alarma_multicanal #(.N(3), .DELAY(4), .RETARDO_MASK(3'b001)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    alarma_multicanal #(.N(8), .DELAY(1), .RETARDO_MASK(8'hF0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        bus_a.armar = 1'b0; bus_a.desarmar = 1'b0; bus_a.sensores = '0; bus_a.mascara = '0;
        bus_b.armar = 1'b0; bus_b.desarmar = 1'b0; bus_b.sensores = '0; bus_b.mascara = '0;

        // Reset raised between edges must act without a clock.
        #3 reset = 1'b1;
        #1;
        chk("rst_estado", 32'(bus_a.estado), 32'h0);
        chk("rst_armado", 32'(bus_a.armado), 32'h0);
        chk("rst_disparo", 32'(bus_a.disparo), 32'h0);
        chk("rst_cuenta", 32'(bus_a.cuenta), 32'h0);
        chk("rst_sirena_b", 32'(bus_b.sirena), 32'h0);
        tick();
        reset = 1'b0;

        // Arm
        bus_a.mascara = 3'b111; bus_a.armar = 1'b1;
        tick();
        bus_a.armar = 1'b0;
        chk("arm_estado", 32'(bus_a.estado), 32'h1);
        chk("arm_armado", 32'(bus_a.armado), 32'h1);
        chk("arm_disparo", 32'(bus_a.disparo), 32'h0);

        // Instantaneous trip latches
        bus_a.sensores = 3'b010;
        tick();
        bus_a.sensores = 3'b000;
        chk("inst_estado", 32'(bus_a.estado), 32'h3);
        chk("inst_sirena", 32'(bus_a.sirena), 32'h1);
        chk("inst_disparo", 32'(bus_a.disparo), 32'h2);
        tick();
        chk("inst_hold", 32'(bus_a.sirena), 32'h1);
        bus_a.desarmar = 1'b1;
        tick();
        bus_a.desarmar = 1'b0;
        chk("dis_estado", 32'(bus_a.estado), 32'h0);
        chk("dis_disparo", 32'(bus_a.disparo), 32'h2);

        // Entry delay runs to alarm
        bus_a.armar = 1'b1;
        tick();
        bus_a.armar = 1'b0;
        chk("rearm_disparo", 32'(bus_a.disparo), 32'h0);
        bus_a.sensores = 3'b001;
        tick();
        bus_a.sensores = 3'b000;
        for (int i = 0; i < 4; i++) begin
            chk("ret_estado", 32'(bus_a.estado), 32'h2);
            chk("ret_cuenta", 32'(bus_a.cuenta), 32'(4 - i));
            chk("ret_aviso", 32'(bus_a.aviso), 32'h1);
            tick();
        end
        chk("ret_fin_estado", 32'(bus_a.estado), 32'h3);
        chk("ret_fin_cuenta", 32'(bus_a.cuenta), 32'h0);
        chk("ret_fin_aviso", 32'(bus_a.aviso), 32'h0);

        // Disarm at cuenta=2 aborts the delay
        bus_a.desarmar = 1'b1;
        tick();
        bus_a.desarmar = 1'b0;
        bus_a.armar = 1'b1;
        tick();
        bus_a.armar = 1'b0;
        bus_a.sensores = 3'b001;
        tick();
        bus_a.sensores = 3'b000;
        tick();
        tick();
        chk("abort_pre", 32'(bus_a.cuenta), 32'h2);
        bus_a.desarmar = 1'b1;
        tick();
        bus_a.desarmar = 1'b0;
        chk("abort_estado", 32'(bus_a.estado), 32'h0);
        chk("abort_cuenta", 32'(bus_a.cuenta), 32'h0);
        chk("abort_sirena", 32'(bus_a.sirena), 32'h0);
        chk("abort_disparo", 32'(bus_a.disparo), 32'h1);

        // Instant trip during the delay cuts it short
        bus_a.armar = 1'b1;
        tick();
        bus_a.armar = 1'b0;
        bus_a.sensores = 3'b001;
        tick();
        bus_a.sensores = 3'b000;
        tick();
        chk("cut_pre", 32'(bus_a.cuenta), 32'h3);
        bus_a.sensores = 3'b100;
        tick();
        bus_a.sensores = 3'b000;
        chk("cut_estado", 32'(bus_a.estado), 32'h3);
        chk("cut_cuenta", 32'(bus_a.cuenta), 32'h0);
        chk("cut_disparo", 32'(bus_a.disparo), 32'h5);

        // Masked channel is ignored
        bus_a.desarmar = 1'b1;
        tick();
        bus_a.desarmar = 1'b0;
        bus_a.mascara = 3'b101;
        bus_a.armar = 1'b1;
        tick();
        bus_a.armar = 1'b0;
        bus_a.sensores = 3'b010;
        for (int i = 0; i < 10; i++) tick();
        bus_a.sensores = 3'b000;
        chk("mask_estado", 32'(bus_a.estado), 32'h1);
        chk("mask_disparo", 32'(bus_a.disparo), 32'h0);

        // Arm and disarm together while disarmed
        bus_a.desarmar = 1'b1;
        tick();
        bus_a.armar = 1'b1;
        tick();
        bus_a.armar = 1'b0; bus_a.desarmar = 1'b0;
        chk("both_estado", 32'(bus_a.estado), 32'h0);

        // Instant and delayed together go straight to alarm
        bus_a.mascara = 3'b111;
        bus_a.armar = 1'b1;
        tick();
        bus_a.armar = 1'b0;
        bus_a.sensores = 3'b011;
        tick();
        bus_a.sensores = 3'b000;
        chk("dual_estado", 32'(bus_a.estado), 32'h3);
        chk("dual_disparo", 32'(bus_a.disparo), 32'h3);

        // Asynchronous reset in the middle of the delay
        bus_a.desarmar = 1'b1;
        tick();
        bus_a.desarmar = 1'b0;
        bus_a.armar = 1'b1;
        tick();
        bus_a.armar = 1'b0;
        bus_a.sensores = 3'b001;
        tick();
        bus_a.sensores = 3'b000;
        chk("arst_pre", 32'(bus_a.estado), 32'h2);
        #2 reset = 1'b1;
        #1;
        chk("arst_estado", 32'(bus_a.estado), 32'h0);
        chk("arst_aviso", 32'(bus_a.aviso), 32'h0);
        chk("arst_cuenta", 32'(bus_a.cuenta), 32'h0);
        chk("arst_disparo", 32'(bus_a.disparo), 32'h0);
        #1 reset = 1'b0;
        tick();

        // Eight channels, one-cycle delay
        bus_b.mascara = 8'hFF; bus_b.armar = 1'b1;
        tick();
        bus_b.armar = 1'b0;
        chk("b_arm", 32'(bus_b.estado), 32'h1);
        bus_b.sensores = 8'h10;
        tick();
        bus_b.sensores = 8'h00;
        chk("b_ret_estado", 32'(bus_b.estado), 32'h2);
        chk("b_ret_cuenta", 32'(bus_b.cuenta), 32'h1);
        chk("b_ret_aviso", 32'(bus_b.aviso), 32'h1);
        tick();
        chk("b_ala_estado", 32'(bus_b.estado), 32'h3);
        chk("b_ala_cuenta", 32'(bus_b.cuenta), 32'h0);
        chk("b_ala_disparo", 32'(bus_b.disparo), 32'h10);
        bus_b.desarmar = 1'b1;
        tick();
        bus_b.desarmar = 1'b0;
        chk("b_dis_disparo", 32'(bus_b.disparo), 32'h10);
        bus_b.armar = 1'b1;
        tick();
        bus_b.armar = 1'b0;
        chk("b_rearm_disparo", 32'(bus_b.disparo), 32'h0);
        bus_b.sensores = 8'h01;
        tick();
        bus_b.sensores = 8'h00;
        chk("b_inst_estado", 32'(bus_b.estado), 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
